// File: rtl/reg_transfer_sequencer.sv
// Register-transfer sequencer: turns MOV / ALU transfer requests into timed
// active-low bus-assert and load strobes for the general purpose registers.
// Every strobe, done and busy is a flop output; req_ready decodes state only.
module reg_transfer_sequencer #(
  parameter int unsigned NUM_REGS      = 4,
  parameter int unsigned IDX_W         = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_op,
  input  logic [IDX_W-1:0]    req_src,
  input  logic [IDX_W-1:0]    req_lhs,
  input  logic [IDX_W-1:0]    req_rhs,
  input  logic [IDX_W-1:0]    req_dst,
  input  logic                hold,
  output logic [NUM_REGS-1:0] a_main_n,
  output logic [NUM_REGS-1:0] a_lhs_n,
  output logic [NUM_REGS-1:0] a_rhs_n,
  output logic [NUM_REGS-1:0] load_n,
  output logic                alu_main_n,
  output logic                done,
  output logic                busy
);

  localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StDrive, StOper, StResult, StLatch} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 op_q, op_d;
  logic [IDX_W-1:0]     src_q, src_d, lhs_q, lhs_d, rhs_q, rhs_d, dst_q, dst_d;
  logic [NUM_REGS-1:0]  a_main_n_q, a_main_n_d, a_lhs_n_q, a_lhs_n_d;
  logic [NUM_REGS-1:0]  a_rhs_n_q, a_rhs_n_d, load_n_q, load_n_d;
  logic                 alu_main_n_q, alu_main_n_d, done_q, done_d, busy_q, busy_d;
  logic                 main_en, oper_en, alu_en;

  // One-hot select of a register; out-of-range indices select nothing.
  function automatic logic [NUM_REGS-1:0] sel(input logic [IDX_W-1:0] idx, input logic en);
    sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (en && (idx == IDX_W'(i))) sel[i] = 1'b1;
    end
  endfunction

  // Next-state, settle counter and request latching.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    src_d   = src_q;
    lhs_d   = lhs_q;
    rhs_d   = rhs_q;
    dst_d   = dst_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d    = req_op;
          src_d   = req_src;
          lhs_d   = req_lhs;
          rhs_d   = req_rhs;
          dst_d   = req_dst;
          cnt_d   = SettleInit;
          state_d = req_op ? StOper : StDrive;
        end
      end
      StDrive, StOper: begin
        if (!hold) begin
          if (cnt_q == 4'd0) state_d = (state_q == StDrive) ? StLatch : StResult;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
      StResult: begin
        if (!hold) state_d = StLatch;
      end
      StLatch: state_d = StIdle;  // hold ignored: the load always completes
      default: state_d = StIdle;
    endcase
  end

  // Strobes are computed from the next state so they come straight out of flops.
  always_comb begin
    main_en      = (state_d == StDrive) || ((state_d == StLatch) && !op_d);
    oper_en      = op_d && ((state_d == StOper) || (state_d == StResult) ||
                            (state_d == StLatch));
    alu_en       = op_d && ((state_d == StResult) || (state_d == StLatch));
    a_main_n_d   = ~sel(src_d, main_en);
    a_lhs_n_d    = ~sel(lhs_d, oper_en);
    a_rhs_n_d    = ~sel(rhs_d, oper_en);
    load_n_d     = ~sel(dst_d, state_d == StLatch);
    alu_main_n_d = ~alu_en;
    done_d       = (state_q == StLatch);
    busy_d       = (state_d != StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      op_q         <= 1'b0;
      src_q        <= '0;
      lhs_q        <= '0;
      rhs_q        <= '0;
      dst_q        <= '0;
      a_main_n_q   <= '1;
      a_lhs_n_q    <= '1;
      a_rhs_n_q    <= '1;
      load_n_q     <= '1;
      alu_main_n_q <= 1'b1;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      src_q        <= src_d;
      lhs_q        <= lhs_d;
      rhs_q        <= rhs_d;
      dst_q        <= dst_d;
      a_main_n_q   <= a_main_n_d;
      a_lhs_n_q    <= a_lhs_n_d;
      a_rhs_n_q    <= a_rhs_n_d;
      load_n_q     <= load_n_d;
      alu_main_n_q <= alu_main_n_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign a_main_n   = a_main_n_q;
  assign a_lhs_n    = a_lhs_n_q;
  assign a_rhs_n    = a_rhs_n_q;
  assign load_n     = load_n_q;
  assign alu_main_n = alu_main_n_q;
  assign done       = done_q;
  assign busy       = busy_q;

`ifndef SYNTHESIS
  // Bus-contention and load-timing invariants.
  a_single_main_driver: assert property (@(posedge clk) disable iff (rst)
    $onehot0({~a_main_n_q, ~alu_main_n_q}));
  a_single_lhs: assert property (@(posedge clk) disable iff (rst) $onehot0(~a_lhs_n_q));
  a_single_rhs: assert property (@(posedge clk) disable iff (rst) $onehot0(~a_rhs_n_q));
  a_single_load: assert property (@(posedge clk) disable iff (rst) $onehot0(~load_n_q));
  a_load_in_latch: assert property (@(posedge clk) disable iff (rst)
    (load_n_q != '1) |-> (state_q == StLatch));
  a_alu_excl_main: assert property (@(posedge clk) disable iff (rst)
    !alu_main_n_q |-> (a_main_n_q == '1));
`endif

endmodule

// File: doc/reg_transfer_sequencer.md
Name: reg_transfer_sequencer

Overview:
- Control-side counterpart to the general purpose registers.
- Turns register-transfer requests (MOV src->dst, or ALU lhs,rhs->dst) into the timed active-low assert and load strobes the registers consume.
- Sequences bus drive, settle and latch phases with registered strobes. Guarantees at most one driver on MainBus and a full released cycle between transfers.
- Sits between instruction decode and the register file / ALU.

Parameters:
- NUM_REGS, 4, number of general purpose registers (one strobe bit each).
- IDX_W, 2, register index width; must satisfy 2**IDX_W >= NUM_REGS.
- SETTLE_CYCLES, 1, cycles the source drives a bus before the load strobe asserts (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept; high only in IDLE.
- req_op  input  1  0 = MOV, 1 = ALU.
- req_src  input  IDX_W  MOV source register (ignored for ALU).
- req_lhs  input  IDX_W  ALU LHS-bus source (ignored for MOV).
- req_rhs  input  IDX_W  ALU RHS-bus source (ignored for MOV).
- req_dst  input  IDX_W  destination register.
- hold  input  1  freezes sequencer in DRIVE/OPER/RESULT.
- a_main_n  output  NUM_REGS  per-register assert-to-MainBus, active low.
- a_lhs_n  output  NUM_REGS  per-register assert-to-LHSBus, active low.
- a_rhs_n  output  NUM_REGS  per-register assert-to-RHSBus, active low.
- load_n  output  NUM_REGS  per-register load-from-MainBus, active low.
- alu_main_n  output  1  ALU result assert-to-MainBus, active low.
- done  output  1  one-cycle pulse: transfer completed.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE.
  - All a_main_n/a_lhs_n/a_rhs_n/load_n = all ones; alu_main_n=1; done=0; busy=0; req_ready=1 after release.
  - Reset mid-transfer aborts it: strobes high after that edge, no load_n pulse, no done.
- All strobe outputs, done and busy are flop outputs (no combinational path from inputs).
  - Exception: req_ready is decoded from state only.
- Accept: req_valid & req_ready at edge N. Fields are latched into internal regs; later input changes are ignored.
- Indices >= NUM_REGS: request accepted, no strobes asserted for that index, done still pulses. Unused ports are flagged only in simulation.
- MOV sequence after edge N:
  - DRIVE for SETTLE_CYCLES cycles: a_main_n[src]=0.
  - LATCH, 1 cycle: a_main_n[src]=0 and load_n[dst]=0.
  - IDLE: all strobes high, done=1 for exactly that cycle.
  - Total busy cycles = SETTLE_CYCLES+1. The register captures at the edge ending LATCH.
- ALU sequence after edge N:
  - OPER for SETTLE_CYCLES cycles: a_lhs_n[lhs]=0, a_rhs_n[rhs]=0.
  - RESULT, 1 cycle: LHS/RHS asserts held, alu_main_n=0.
  - LATCH, 1 cycle: LHS/RHS asserts and alu_main_n held, load_n[dst]=0.
  - IDLE with done=1. Busy cycles = SETTLE_CYCLES+2.
- lhs==rhs is legal: the same register asserts on both buses.
- src==dst (MOV) is legal and runs normally. dst equal to lhs or rhs (ALU) is legal; the source asserts are held through LATCH.
- Invariants, checked by assertion:
  - At most one of {a_main_n bits, alu_main_n} low in any cycle.
  - ≤1 bit low per LHS/RHS vector.
  - ≤1 bit low in load_n, and load_n low only in LATCH.
  - Never a_main_n and load_n low for different registers while alu_main_n is low.
- hold=1 in DRIVE/OPER/RESULT: state and settle counter freeze, strobes unchanged.
  - hold is ignored in LATCH (the load always completes) and in IDLE.
- Back-to-back: the done cycle is the IDLE cycle with req_ready=1. A request accepted at that edge starts DRIVE/OPER next cycle, so there is always ≥1 all-released cycle between transfers (bus turnaround).
- Settle counter: IDX-independent, width 4, loaded with SETTLE_CYCLES-1, counts down to 0.

Test Plan:
1. Reset then MOV src=2,dst=0, SETTLE=1: edge N accept → cycle N+1 a_main_n=1011; N+2 a_main_n=1011, load_n=1110; N+3 all 1111, done=1, req_ready=1.
2. ALU lhs=1,rhs=3,dst=2, SETTLE=2: two OPER cycles (a_lhs_n=1101, a_rhs_n=0111) → RESULT alu_main_n=0 → LATCH load_n=1011 → done; busy high exactly 4 cycles.
3. hold=1 for 3 cycles during DRIVE of a MOV: a_main_n stays 1011, no load_n; after hold drops LATCH occurs; busy cycles = 2+3; hold asserted during LATCH has no effect.
4. rst pulsed in LATCH of a MOV: next cycle all strobes 1111, alu_main_n=1, done never pulses, req_ready=1 after release.
5. Back-to-back MOV 0→1 then ALU 2,2→3 with req_valid held high: exactly one all-released cycle (with done=1) between them; bus-contention assertions never fire over 1000 random requests incl. src==dst and lhs==rhs.
